// File: rtl/execute_stage_md_if.sv
// Execute-stage bus: decoded E-stage controls/operands in, EX/MEM register and redirect out.
interface execute_stage_md_if #(
  parameter int unsigned XLEN = 32
);
  logic            FlushE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            ALUSrcE;
  logic [3:0]      ALUControlE;
  logic            MulDivE;
  logic [2:0]      MulDivOpE;
  logic            BranchEnE;
  logic [2:0]      BranchOpE;
  logic            JumpE;
  logic            JalrE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] ResultW;

  logic            BusyE;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUControlE, MulDivE, MulDivOpE,
           BranchEnE, BranchOpE, JumpE, JalrE, ForwardAE, ForwardBE, RD1E, RD2E, ImmExtE,
           PCE, PCPlus4E, RdE, ResultW,
    input  BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );

  modport slave (
    input  FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUControlE, MulDivE, MulDivOpE,
           BranchEnE, BranchOpE, JumpE, JalrE, ForwardAE, ForwardBE, RD1E, RD2E, ImmExtE,
           PCE, PCPlus4E, RdE, ResultW,
    output BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage_md.sv
// RV32IM execute stage: forwarding, ALU, branch/jump resolution, EX/MEM register and an
// iterative one-bit-per-cycle multiply/divide unit that stalls the front of the pipe while busy.
module execute_stage_md #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 6
) (
  input logic               clk,
  input logic               rst,
  execute_stage_md_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PW  = 2 * XLEN;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [PW-1:0]   acc;
  logic [XLEN-1:0] opd, dvd_l, wd_l, pc4_l;
  logic [2:0]      op_l;
  logic            neg_q, neg_r, dz_l, regw_l, memw_l;
  logic [1:0]      rsrc_l;
  logic [4:0]      rd_l;

  logic [XLEN-1:0] src_a, fwd_b, alu_b, alu_res;
  logic            busy;

  // Operand forwarding
  always_comb begin
    src_a = bus.RD1E;
    fwd_b = bus.RD2E;
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUResultM;
      default: src_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = bus.ALUResultM;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign alu_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

  logic [SHW-1:0] shamt;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.ALUControlE)
      ALU_ADD:  alu_res = src_a + alu_b;
      ALU_SUB:  alu_res = src_a - alu_b;
      ALU_AND:  alu_res = src_a & alu_b;
      ALU_OR:   alu_res = src_a | alu_b;
      ALU_XOR:  alu_res = src_a ^ alu_b;
      ALU_SLT:  alu_res = XLEN'($signed(src_a) < $signed(alu_b));
      ALU_SLTU: alu_res = XLEN'(src_a < alu_b);
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
      ALU_LUI:  alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch flags from A - B on the register operands; carry set means no borrow
  logic [XLEN:0] cmp;
  logic          c_f, n_f, v_f, z_f, br_cond;
  assign cmp = {1'b0, src_a} + {1'b0, ~fwd_b} + {{XLEN{1'b0}}, 1'b1};
  assign c_f = cmp[XLEN];
  assign n_f = cmp[XLEN-1];
  assign v_f = (src_a[XLEN-1] ^ fwd_b[XLEN-1]) & (cmp[XLEN-1] ^ src_a[XLEN-1]);
  assign z_f = (cmp[XLEN-1:0] == '0);

  always_comb begin
    br_cond = 1'b0;
    case (bus.BranchOpE)
      BR_BEQ:  br_cond = z_f;
      BR_BNE:  br_cond = ~z_f;
      BR_BLT:  br_cond = n_f ^ v_f;
      BR_BGE:  br_cond = ~(n_f ^ v_f);
      BR_BLTU: br_cond = ~c_f;
      BR_BGEU: br_cond = c_f;
      default: br_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum      = src_a + bus.ImmExtE;
  assign bus.PCTargetE = bus.JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : bus.PCE + bus.ImmExtE;

  assign busy       = rst & ((state == S_BUSY) |
                             ((state == S_IDLE) & bus.MulDivE & ~bus.FlushE));
  assign bus.BusyE  = busy;
  assign bus.PCSrcE = ~busy & (bus.JumpE | (bus.BranchEnE & br_cond));

  // Signed ops run on magnitudes; the sign is restored when the result is taken
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.MulDivOpE)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MD_MULHSU: a_sgn = 1'b1;
      default:   a_sgn = 1'b0;
    endcase
  end
  assign a_neg = a_sgn & src_a[XLEN-1];
  assign b_neg = b_sgn & fwd_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -fwd_b : fwd_b;

  // One iteration: shift-add multiply (multiplier in the low half) or restoring divide
  logic [XLEN:0] mul_sum, div_tmp, div_diff;
  logic [PW-1:0] step_acc;
  always_comb begin
    mul_sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    div_tmp  = {acc[PW-1:XLEN], acc[XLEN-1]};
    div_diff = div_tmp - {1'b0, opd};
    step_acc = {mul_sum, acc[XLEN-1:1]};
    if (op_l[2]) begin
      if (!div_diff[XLEN]) step_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 step_acc = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rem, md_res;
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_r ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];

  always_comb begin
    md_res = '0;
    case (op_l)
      MD_MUL:                       md_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod[PW-1:XLEN];
      MD_DIV, MD_DIVU:              md_res = dz_l ? '1 : quo;
      default:                      md_res = dz_l ? dvd_l : rem;
    endcase
  end

  // M-unit FSM and EX/MEM register; every cycle without a result loads a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      acc            <= '0;
      opd            <= '0;
      dvd_l          <= '0;
      wd_l           <= '0;
      pc4_l          <= '0;
      op_l           <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      dz_l           <= 1'b0;
      regw_l         <= 1'b0;
      memw_l         <= 1'b0;
      rsrc_l         <= '0;
      rd_l           <= '0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RdM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
    end else begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RdM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
      if (bus.FlushE) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.MulDivE) begin
              acc    <= {{XLEN{1'b0}}, a_mag};
              opd    <= b_mag;
              dvd_l  <= src_a;
              wd_l   <= fwd_b;
              pc4_l  <= bus.PCPlus4E;
              op_l   <= bus.MulDivOpE;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz_l   <= (fwd_b == '0);
              regw_l <= bus.RegWriteE;
              memw_l <= bus.MemWriteE;
              rsrc_l <= bus.ResultSrcE;
              rd_l   <= bus.RdE;
              cnt    <= '0;
              state  <= S_BUSY;
            end else begin
              bus.RegWriteM  <= bus.RegWriteE;
              bus.MemWriteM  <= bus.MemWriteE;
              bus.ResultSrcM <= bus.ResultSrcE;
              bus.RdM        <= bus.RdE;
              bus.ALUResultM <= alu_res;
              bus.WriteDataM <= fwd_b;
              bus.PCPlus4M   <= bus.PCPlus4E;
            end
          end
          S_BUSY: begin
            acc <= step_acc;
            cnt <= cnt + CNTW'(1);
            if (cnt == CNTW'(XLEN - 1)) begin
              cnt   <= '0;
              state <= S_DONE;
            end
          end
          S_DONE: begin
            bus.RegWriteM  <= regw_l;
            bus.MemWriteM  <= memw_l;
            bus.ResultSrcM <= rsrc_l;
            bus.RdM        <= rd_l;
            bus.ALUResultM <= md_res;
            bus.WriteDataM <= wd_l;
            bus.PCPlus4M   <= pc4_l;
            state          <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
